// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter and its per-source FIFOs.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MEM = 1;

    typedef struct packed {
        logic [XLEN-1:0]       data;
        logic [REG_ADDR_W-1:0] rd;
    } wb_entry_t;

    // Channel index reached by stepping `offset` places from `base`, wrapping at n.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Small per-source result FIFO. Pushes and pops are assumed legal; the arbiter
// gates push with !full and only pops a non-empty FIFO.
module wb_src_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_pkg::wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);
    import wb_pkg::*;

    // A depth of one still needs a 1-bit pointer; it simply never moves.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    assign full     = (r_count == FULL_CNT);
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the count alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && pop) begin
            assert (!empty);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back stage: one FIFO per producer channel, drained round-robin into a
// single registered register-file write port.
module wb_arbiter #(
    parameter int XLEN    = wb_pkg::XLEN,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_SRC*XLEN-1:0]               src_res,
    input  logic [NUM_SRC*wb_pkg::REG_ADDR_W-1:0] src_rd,
    input  logic [NUM_SRC-1:0]                    src_v,
    output logic [NUM_SRC-1:0]                    src_ok,
    output logic [XLEN-1:0]                       result,
    output logic [wb_pkg::REG_ADDR_W-1:0]         rd,
    output logic                                  result_v
);
    import wb_pkg::*;

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        logic [XLEN-1:0]       data;
        logic [REG_ADDR_W-1:0] rd;
    } entry_t;

    entry_t                w_push_data [NUM_SRC];
    entry_t                w_pop_data  [NUM_SRC];
    logic [NUM_SRC-1:0]    w_push;
    logic [NUM_SRC-1:0]    w_pop;
    logic [NUM_SRC-1:0]    w_full;
    logic [NUM_SRC-1:0]    w_empty;
    logic [NUM_SRC-1:0]    w_ok;
    logic [PTR_W-1:0]      w_gnt;
    logic                  w_found;

    logic [PTR_W-1:0]      r_ptr;
    logic [XLEN-1:0]       r_result;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_result_v;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_push_data[gi] = '{data: src_res[gi*XLEN +: XLEN],
                                       rd:   src_rd[gi*REG_ADDR_W +: REG_ADDR_W]};
            // Ready reflects FIFO state only; it is never combined with a pending pop.
            assign w_ok[gi]   = rst_n && !w_full[gi];
            // Writes to x0 complete the handshake but are never stored.
            assign w_push[gi] = src_v[gi] && w_ok[gi] && (w_push_data[gi].rd != '0);
            assign w_pop[gi]  = w_found && (w_gnt == PTR_W'(gi));

            wb_src_fifo #(
                .DEPTH   (DEPTH),
                .entry_t (entry_t)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (w_push[gi]),
                .push_data (w_push_data[gi]),
                .pop       (w_pop[gi]),
                .pop_data  (w_pop_data[gi]),
                .full      (w_full[gi]),
                .empty     (w_empty[gi])
            );
        end
    endgenerate

    // First non-empty channel scanning from r_ptr upward with wrap.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = PTR_W'(rr_index(int'(r_ptr), k, NUM_SRC));
            if (!w_found && !w_empty[idx]) begin
                w_found = 1'b1;
                w_gnt   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_result   <= '0;
            r_rd       <= '0;
            r_result_v <= 1'b0;
        end else begin
            r_result_v <= w_found;
            if (w_found) begin
                r_result <= w_pop_data[w_gnt].data;
                r_rd     <= w_pop_data[w_gnt].rd;
                r_ptr    <= PTR_W'(rr_index(int'(w_gnt), 1, NUM_SRC));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && r_result_v) begin
            assert (r_rd != '0);
        end
    end

    assign src_ok   = w_ok;
    assign result   = r_result;
    assign rd       = r_rd;
    assign result_v = r_result_v;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a 2-source instance for latency, collision,
// backpressure and x0 cases, and a 4-source instance for round-robin fairness.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int ALU = WB_SRC_ALU;
    localparam int MEM = WB_SRC_MEM;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [2*XLEN-1:0] s2_res = '0;
    logic [9:0]        s2_rd  = '0;
    logic [1:0]        s2_v   = '0;
    logic [1:0]        s2_ok;
    logic [XLEN-1:0]   r2_res;
    logic [4:0]        r2_rd;
    logic              r2_v;

    logic [4*XLEN-1:0] s4_res = '0;
    logic [19:0]       s4_rd  = '0;
    logic [3:0]        s4_v   = '0;
    logic [3:0]        s4_ok;
    logic [XLEN-1:0]   r4_res;
    logic [4:0]        r4_rd;
    logic              r4_v;

    int n_checks = 0;
    int n_pass   = 0;
    int wr2      = 0;
    wb_entry_t  sb[$];
    logic [4:0] log4[$];

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XLEN), .NUM_SRC(2), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .src_res(s2_res), .src_rd(s2_rd), .src_v(s2_v),
        .src_ok(s2_ok), .result(r2_res), .rd(r2_rd), .result_v(r2_v)
    );

    wb_arbiter #(.XLEN(XLEN), .NUM_SRC(4), .DEPTH(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .src_res(s4_res), .src_rd(s4_rd), .src_v(s4_v),
        .src_ok(s4_ok), .result(r4_res), .rd(r4_rd), .result_v(r4_v)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic wb_entry_t mk(input logic [31:0] d, input logic [4:0] r);
        wb_entry_t e;
        e.data = d;
        e.rd   = r;
        return e;
    endfunction

    task automatic drive2(input int ch, input logic [31:0] d, input logic [4:0] r);
        s2_res[ch*XLEN +: XLEN] = d;
        s2_rd[ch*5 +: 5]        = r;
    endtask

    task automatic drive4(input int ch, input logic [31:0] d, input logic [4:0] r);
        s4_res[ch*XLEN +: XLEN] = d;
        s4_rd[ch*5 +: 5]        = r;
    endtask

    // Scoreboard for the 2-source instance: every write must match the next expected entry.
    always @(negedge clk) begin
        if (r2_v === 1'b1) begin
            wr2++;
            if (sb.size() == 0) begin
                check("sb_unexpected_write", {31'd0, r2_v}, 32'd0);
            end else begin
                wb_entry_t e;
                e = sb.pop_front();
                check("sb_result", r2_res, e.data);
                check("sb_rd", {27'd0, r2_rd}, {27'd0, e.rd});
            end
        end
        if (r4_v === 1'b1) begin
            log4.push_back(r4_rd);
        end
    end

    initial begin
        int wr_base;
        int n_bad;
        int n_log;
        int cnt[4];

        // Reset held with every producer valid.
        drive2(ALU, 32'h5555_0001, 5'd3);
        drive2(MEM, 32'h5555_0002, 5'd7);
        s2_v = 2'b11;
        for (int c = 0; c < 4; c++) drive4(c, 32'h100 + c, 5'(c + 1));
        s4_v = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ok2", {30'd0, s2_ok}, 32'd0);
            check("rst_ok4", {28'd0, s4_ok}, 32'd0);
            check("rst_v2", {31'd0, r2_v}, 32'd0);
            check("rst_v4", {31'd0, r4_v}, 32'd0);
            check("rst_res2", r2_res, 32'd0);
            check("rst_rd2", {27'd0, r2_rd}, 32'd0);
        end
        s2_v  = 2'b00;
        s4_v  = 4'h0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_v2", {31'd0, r2_v}, 32'd0);
            check("post_rst_v4", {31'd0, r4_v}, 32'd0);
        end
        check("post_rst_ok2", {30'd0, s2_ok}, 32'h3);
        check("post_rst_ok4", {28'd0, s4_ok}, 32'hF);

        // Single ALU write: visible after the second edge, for one cycle.
        drive2(ALU, 32'h0000_00AA, 5'd5);
        s2_v = 2'b01;
        sb.push_back(mk(32'h0000_00AA, 5'd5));
        tick();
        s2_v = 2'b00;
        check("single_lat_k", {31'd0, r2_v}, 32'd0);
        tick();
        check("single_v", {31'd0, r2_v}, 32'd1);
        check("single_res", r2_res, 32'h0000_00AA);
        check("single_rd", {27'd0, r2_rd}, 32'd5);
        tick();
        check("single_one_cycle", {31'd0, r2_v}, 32'd0);

        // Collision from ptr=0: ALU then MEM, ptr wraps back to 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive2(ALU, 32'h11, 5'd3);
        drive2(MEM, 32'h22, 5'd7);
        s2_v = 2'b11;
        sb.push_back(mk(32'h11, 5'd3));
        sb.push_back(mk(32'h22, 5'd7));
        tick();
        s2_v = 2'b00;
        check("coll_lat_k", {31'd0, r2_v}, 32'd0);
        tick();
        check("coll_first_v", {31'd0, r2_v}, 32'd1);
        check("coll_first_alu", {27'd0, r2_rd}, 32'd3);
        tick();
        check("coll_second_v", {31'd0, r2_v}, 32'd1);
        check("coll_second_mem", {27'd0, r2_rd}, 32'd7);
        tick();
        check("coll_idle", {31'd0, r2_v}, 32'd0);
        drive2(ALU, 32'h33, 5'd3);
        drive2(MEM, 32'h44, 5'd7);
        s2_v = 2'b11;
        sb.push_back(mk(32'h33, 5'd3));
        sb.push_back(mk(32'h44, 5'd7));
        tick();
        s2_v = 2'b00;
        tick();
        check("coll_ptr0_alu_first", {27'd0, r2_rd}, 32'd3);
        tick();
        check("coll_ptr0_mem_second", {27'd0, r2_rd}, 32'd7);
        tick();

        // Backpressure: MEM fills after two entries, third waits for a MEM pop.
        wr_base = wr2;
        sb.push_back(mk(32'hA0, 5'd3));
        sb.push_back(mk(32'hB0, 5'd7));
        sb.push_back(mk(32'hA1, 5'd3));
        sb.push_back(mk(32'hB1, 5'd7));
        sb.push_back(mk(32'hA2, 5'd3));
        sb.push_back(mk(32'hB2, 5'd7));
        drive2(ALU, 32'hA0, 5'd3);
        drive2(MEM, 32'hB0, 5'd7);
        s2_v = 2'b11;
        tick();
        drive2(ALU, 32'hA1, 5'd3);
        drive2(MEM, 32'hB1, 5'd7);
        tick();
        check("bp_mem_full", {30'd0, s2_ok}, 32'h1);
        drive2(ALU, 32'hA2, 5'd3);
        drive2(MEM, 32'hB2, 5'd7);
        tick();
        check("bp_mem_freed", {30'd0, s2_ok}, 32'h2);
        s2_v = 2'b10;
        tick();
        check("bp_mem_refull", {30'd0, s2_ok}, 32'h1);
        s2_v = 2'b00;
        for (int i = 0; i < 4; i++) tick();
        check("bp_drained", sb.size(), 32'd0);
        check("bp_write_count", wr2 - wr_base, 32'd6);

        // x0 drop: accepted, never written; next write unaffected.
        wr_base = wr2;
        drive2(ALU, 32'hDEAD, 5'd0);
        s2_v = 2'b01;
        check("x0_ok_before", {31'd0, s2_ok[ALU]}, 32'd1);
        tick();
        s2_v = 2'b00;
        check("x0_ok_after", {30'd0, s2_ok}, 32'h3);
        tick();
        check("x0_no_write_a", {31'd0, r2_v}, 32'd0);
        tick();
        check("x0_no_write_b", {31'd0, r2_v}, 32'd0);
        drive2(ALU, 32'h1, 5'd1);
        s2_v = 2'b01;
        sb.push_back(mk(32'h1, 5'd1));
        tick();
        s2_v = 2'b00;
        check("x0_next_lat_k", {31'd0, r2_v}, 32'd0);
        tick();
        check("x0_next_v", {31'd0, r2_v}, 32'd1);
        check("x0_next_rd", {27'd0, r2_rd}, 32'd1);
        tick();
        check("x0_total_writes", wr2 - wr_base, 32'd1);

        // Fairness on 4 sources, all continuously valid.
        for (int c = 0; c < 4; c++) drive4(c, 32'h100 + c, 5'(c + 1));
        log4.delete();
        s4_v = 4'hF;
        for (int i = 0; i < 200 && log4.size() < 64; i++) tick();
        check("rr_64_writes", {31'd0, log4.size() >= 64}, 32'd1);
        n_bad = 0;
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int i = 0; i < 64 && i < log4.size(); i++) begin
            if (log4[i] != 5'((i % 4) + 1)) n_bad++;
            if (log4[i] >= 5'd1 && log4[i] <= 5'd4) cnt[int'(log4[i]) - 1]++;
        end
        check("rr_order", n_bad, 32'd0);
        for (int c = 0; c < 4; c++) check($sformatf("rr_share_ch%0d", c), cnt[c], 32'd16);

        // Mid-stream reset: no stale writes, ptr back to 0.
        rst_n = 1'b0;
        tick();
        check("mid_rst_ok4", {28'd0, s4_ok}, 32'd0);
        check("mid_rst_v4", {31'd0, r4_v}, 32'd0);
        s4_v  = 4'h0;
        rst_n = 1'b1;
        n_log = log4.size();
        for (int i = 0; i < 4; i++) tick();
        check("mid_rst_no_stale", log4.size() - n_log, 32'd0);
        s4_v = 4'b1010;
        tick();
        s4_v = 4'h0;
        tick();
        check("mid_rst_ptr0_v", {31'd0, r4_v}, 32'd1);
        check("mid_rst_ptr0_ch1", {27'd0, r4_rd}, 32'd2);
        tick();
        check("mid_rst_ptr0_ch3", {27'd0, r4_rd}, 32'd4);
        tick();
        check("mid_rst_idle", {31'd0, r4_v}, 32'd0);
        check("sb_empty_end", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
